deser_lane_arbiter: RTL and testbench

//  Shares one 16-bit serial deserializer between NUM_LANES serial sources.

---
 rtl/deser_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 24 ++
 rtl/deser_lane_arbiter.sv | 145 ++++++++++++++
 tb/tb_deser_lane_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/deser_arb_pkg.sv
// Shared types for the deserializer lane arbiter.
package deser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam int FRAME_BITS_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting index strictly after i_last, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [LW-1:0] o_idx,
    output logic          o_found
);

    // Cyclic search starting one past the previous owner; i_last itself is checked last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!o_found && i_req[(int'(i_last) + k) % N]) begin
                o_idx   = LW'((int'(i_last) + k) % N);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/deser_lane_arbiter.sv
// Time-shares one serial deserializer across NUM_LANES sources, one frame per grant,
// and tags each returned word (or abort) with the lane that produced it.
module deser_lane_arbiter
    import deser_arb_pkg::*;
#(
    parameter  int NUM_LANES  = 4,
    parameter  int FRAME_BITS = FRAME_BITS_DEF,
    parameter  int TIMEOUT    = 32,
    localparam int LANE_W     = $clog2(NUM_LANES)
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [NUM_LANES-1:0]  req_i,
    input  logic [NUM_LANES-1:0]  data_i,
    input  logic [NUM_LANES-1:0]  data_val_i,
    output logic [NUM_LANES-1:0]  grant_o,
    output logic                  ser_data_o,
    output logic                  ser_data_val_o,
    output logic                  ser_srst_o,
    input  logic [FRAME_BITS-1:0] deser_data_i,
    input  logic                  deser_data_val_i,
    output logic [FRAME_BITS-1:0] word_o,
    output logic [LANE_W-1:0]     word_lane_o,
    output logic                  word_val_o,
    output logic                  abort_o
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int ICW = $clog2(TIMEOUT + 1);

    state_t                 r_state, w_state_nxt;
    logic [LANE_W-1:0]      r_lane, r_last_lane;
    logic [NUM_LANES-1:0]   r_grant;
    logic [BCW-1:0]         r_bit_cnt;
    logic [ICW-1:0]         r_idle_cnt;
    logic                   r_wait_cnt;
    logic [FRAME_BITS-1:0]  r_word;
    logic [LANE_W-1:0]      r_word_lane;
    logic                   r_word_val, r_abort;

    logic [LANE_W-1:0]      w_pick_idx;
    logic                   w_pick_found;
    logic                   w_lane_val, w_last_bit, w_timeout, w_streaming;

    rr_pick #(.N(NUM_LANES), .LW(LANE_W)) u_pick (
        .i_req   (req_i),
        .i_last  (r_last_lane),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_streaming = (r_state == STREAM);
    assign w_lane_val  = data_val_i[r_lane];
    assign w_last_bit  = w_lane_val && (r_bit_cnt == BCW'(FRAME_BITS - 1));
    assign w_timeout   = !w_lane_val && (r_idle_cnt == ICW'(TIMEOUT - 1));

    // Only the owning lane reaches the deserializer, and only while a frame is open.
    assign ser_data_o     = w_streaming ? data_i[r_lane] : 1'b0;
    assign ser_data_val_o = w_streaming ? w_lane_val     : 1'b0;
    // ABORT lasts exactly one cycle, so this is the one-cycle flush pulse.
    assign ser_srst_o     = srst_i | (r_state == ABORT);

    assign grant_o     = r_grant;
    assign word_o      = r_word;
    assign word_lane_o = r_word_lane;
    assign word_val_o  = r_word_val;
    assign abort_o     = r_abort;

    // State register.
    always_ff @(posedge clk_i) begin
        if (srst_i) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: one frame per grant, bounded waits for both the source and the deserializer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_found) w_state_nxt = STREAM;
            STREAM:  if (w_last_bit)        w_state_nxt = WAIT;
                     else if (w_timeout)    w_state_nxt = ABORT;
            WAIT:    if (deser_data_val_i)  w_state_nxt = IDLE;
                     else if (r_wait_cnt)   w_state_nxt = ABORT;
            ABORT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, counters and tagged output registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_lane      <= '0;
            r_last_lane <= LANE_W'(NUM_LANES - 1);
            r_grant     <= '0;
            r_bit_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_wait_cnt  <= 1'b0;
            r_word      <= '0;
            r_word_lane <= '0;
            r_word_val  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_word_val <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_lane     <= w_pick_idx;
                        r_grant    <= NUM_LANES'(1) << w_pick_idx;
                        r_bit_cnt  <= '0;
                        r_idle_cnt <= '0;
                        r_wait_cnt <= 1'b0;
                    end
                end
                STREAM: begin
                    if (w_lane_val) begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                    if (w_last_bit || w_timeout) r_grant <= '0;
                end
                WAIT: begin
                    if (deser_data_val_i) begin
                        r_word      <= deser_data_i;
                        r_word_lane <= r_lane;
                        r_word_val  <= 1'b1;
                        r_last_lane <= r_lane;
                    end else begin
                        r_wait_cnt <= 1'b1;
                    end
                end
                ABORT: begin
                    r_abort     <= 1'b1;
                    r_word_lane <= r_lane;
                    r_last_lane <= r_lane;
                    r_grant     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_lane_arbiter.sv
// Scoreboard bench: arbiter plus a behavioural 16-bit MSB-first deserializer.
module tb_deser_lane_arbiter;

    localparam int NL = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic [3:0]  req, din, dval, grant;
    logic        ser_d, ser_v, ser_srst;
    logic [15:0] deser_d;
    logic        deser_v;
    logic [15:0] word;
    logic [1:0]  wlane;
    logic        wval, abrt;

    deser_lane_arbiter #(.NUM_LANES(NL), .FRAME_BITS(16), .TIMEOUT(32)) dut (
        .clk_i(clk), .srst_i(srst), .req_i(req), .data_i(din), .data_val_i(dval),
        .grant_o(grant), .ser_data_o(ser_d), .ser_data_val_o(ser_v), .ser_srst_o(ser_srst),
        .deser_data_i(deser_d), .deser_data_val_i(deser_v),
        .word_o(word), .word_lane_o(wlane), .word_val_o(wval), .abort_o(abrt)
    );

    // Deserializer: shifts valid bits MSB-first, presents the word the cycle after bit 16.
    logic [15:0] ds_sh;
    int          ds_cnt;
    always_ff @(posedge clk) begin
        if (ser_srst) begin
            ds_sh <= '0; ds_cnt <= 0; deser_v <= 1'b0; deser_d <= '0;
        end else begin
            deser_v <= 1'b0;
            if (ser_v) begin
                ds_sh <= {ds_sh[14:0], ser_d};
                if (ds_cnt == 15) begin
                    deser_d <= {ds_sh[14:0], ser_d};
                    deser_v <= 1'b1;
                    ds_cnt  <= 0;
                end else begin
                    ds_cnt <= ds_cnt + 1;
                end
            end
        end
    end

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_abort;
        int          lane;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errs = 0, checks = 0;
    int          exp_last = NL - 1;
    logic [15:0] lane_data[NL];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first requester after the previous owner, cyclically.
    function automatic int rr_model(input logic [3:0] r, input int last);
        for (int k = 1; k <= NL; k++)
            if (r[(last + k) % NL]) return (last + k) % NL;
        return -1;
    endfunction

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!srst && (wval || abrt)) begin
            chk("pulse_exclusive", 32'(wval & abrt), 32'd0);
            if (sb.size() == 0) begin
                checks++; errs++;
                $display("FAIL unexpected_output: got val=%0d abort=%0d lane=%0d want none", wval, abrt, wlane);
            end else begin
                e = sb.pop_front();
                chk("out_kind", 32'(abrt), 32'(e.is_abort));
                chk("out_lane", 32'(wlane), 32'(e.lane));
                chk("out_cycle", 32'(cyc), 32'(e.cyc));
                if (!e.is_abort) chk("out_word", 32'(word), 32'(e.data));
            end
        end
    end

    // Drive one cycle (g<0: all lanes quiet), check the serial mux, advance past the edge.
    task automatic step(input int g, input logic b, input logic v);
        for (int l = 0; l < NL; l++) begin
            if (g < 0)       begin din[l] = 1'b0; dval[l] = 1'b0; end
            else if (l == g) begin din[l] = b;    dval[l] = v;    end
            else             begin din[l] = 1'($urandom); dval[l] = 1'($urandom); end
        end
        #1;
        if (g >= 0) begin
            chk("ser_val", 32'(ser_v), 32'(v));
            chk("ser_data", 32'(ser_d), 32'(b));
        end
        @(posedge clk); #1;
    endtask

    // reqmode: 0 drop granted bit, 1 keep all requests, 2 drop all requests once granted.
    task automatic do_frame(input int nbits, input int gap, input bit stall, input int reqmode, input bit rst_mid);
        int g, t_last, nsr, to, gp;
        logic [3:0] req_seen;
        g = -1; t_last = cyc; req_seen = req;
        for (int i = 0; i < 12 && g < 0; i++) begin
            if (grant != 0) begin
                for (int l = 0; l < NL; l++) if (grant[l]) g = l;
            end else step(-1, 1'b0, 1'b0);
        end
        if (g < 0) begin
            checks++; errs++;
            $display("FAIL grant_timeout: got grant=%0h want a grant for req=%0h", grant, req_seen);
            return;
        end
        chk("grant_onehot", 32'($countones(grant)), 32'd1);
        chk("grant_lane", 32'(g), 32'(rr_model(req_seen, exp_last)));
        if (reqmode == 0) req[g] = 1'b0;
        else if (reqmode == 2) req = '0;
        for (int i = 0; i < nbits; i++) begin
            gp = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (i > 0) repeat (gp) step(g, 1'($urandom), 1'b0);
            t_last = cyc;
            step(g, lane_data[g][15-i], 1'b1);
        end
        if (rst_mid) begin
            srst = 1'b1;
            step(-1, 1'b0, 1'b0);
            srst = 1'b0;
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_word", 32'(word), 32'd0);
            chk("rst_lane", 32'(wlane), 32'd0);
            exp_last = NL - 1;
            repeat (4) step(-1, 1'b0, 1'b0);
            return;
        end
        if (stall) begin
            sb.push_back('{is_abort: 1'b1, lane: g, data: 16'h0, cyc: t_last + 34});
            nsr = 0;
            for (int i = 1; i <= 34; i++) begin
                if (ser_srst) begin
                    nsr++;
                    chk("srst_cycle", 32'(cyc), 32'(t_last + 33));
                    chk("abort_grant", 32'(grant), 32'd0);
                end
                step(g, 1'b0, 1'b0);
            end
            chk("srst_pulses", 32'(nsr), 32'd1);
        end else begin
            sb.push_back('{is_abort: 1'b0, lane: g, data: lane_data[g], cyc: t_last + 2});
            chk("grant_drop", 32'(grant), 32'd0);
        end
        exp_last = g;
        to = 0;
        while (sb.size() != 0 && to < 60) begin step(-1, 1'b0, 1'b0); to++; end
        if (sb.size() != 0) begin
            checks++; errs++;
            $display("FAIL drain_timeout: got %0d pending events want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        srst = 1'b1; req = '0; din = '0; dval = '0;
        for (int l = 0; l < NL; l++) lane_data[l] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant0", 32'(grant), 32'd0);
        chk("rst_word0", 32'(word), 32'd0);
        chk("rst_wval0", 32'(wval), 32'd0);
        chk("rst_abort0", 32'(abrt), 32'd0);
        chk("rst_lane0", 32'(wlane), 32'd0);
        chk("rst_sersrst", 32'(ser_srst), 32'd1);
        srst = 1'b0;
        @(posedge clk); #1;

        // Single lane, contiguous bits.
        lane_data[1] = 16'hA5C3; req = 4'b0010;
        do_frame(16, 0, 1'b0, 0, 1'b0);

        // All lanes requesting continuously: strict rotation.
        for (int l = 0; l < NL; l++) lane_data[l] = 16'($urandom);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) do_frame(16, 0, 1'b0, (k == 7) ? 2 : 1, 1'b0);

        // Gappy source below the timeout.
        lane_data[2] = 16'h5A3C; req = 4'b0100;
        do_frame(16, 5, 1'b0, 0, 1'b0);

        // Stall then a clean frame after the flush.
        lane_data[3] = 16'hBEEF; req = 4'b1000;
        do_frame(7, 0, 1'b1, 0, 1'b0);
        lane_data[0] = 16'h1234; req = 4'b0001;
        do_frame(16, 0, 1'b0, 0, 1'b0);

        // Isolation: neighbours toggle while lane 0 owns the slot.
        lane_data[0] = 16'hFFFF; req = 4'b0001;
        do_frame(16, 1, 1'b0, 0, 1'b0);

        // Reset mid-frame, then lane 0 wins over lane 3.
        lane_data[2] = 16'h0F0F; req = 4'b0100;
        do_frame(9, 0, 1'b0, 0, 1'b1);
        lane_data[0] = 16'hC0DE; req = 4'b1001;
        do_frame(16, 0, 1'b0, 0, 1'b0);
        do_frame(16, 0, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 24 || req != 0; k++) begin
            if (req == 0) begin
                req = 4'($urandom_range(1, 15));
                for (int l = 0; l < NL; l++) lane_data[l] = 16'($urandom);
            end
            if ($urandom_range(0, 5) == 0) do_frame(int'($urandom_range(1, 15)), -1, 1'b1, 0, 1'b0);
            else                           do_frame(16, -1, 1'b0, 0, 1'b0);
            if (k > 200) break;
        end

        repeat (5) step(-1, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
